ovf_cmd_tx: RTL and testbench
=============================

OVF_CMD_TX -- requirements
Module: ovf_cmd_tx

Interface
REQ-001 Parameter: OPC, 3'h1, opcode placed in header bits [2:0].
REQ-002 Port: clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: req_v  in  1  write request valid.
REQ-005 Port: req_sel  in  2  target register: 0=R8 (8b), 1=R4 (4b), 2=RC (12b), 3=invalid.
REQ-006 Port: req_d  in  16  requested value, wider than any target field.
REQ-007 Port: req_rdy  out  1  request accepted on the posedge where req_v && req_rdy.
REQ-008 Port: tx_d  out  8  command byte.
REQ-009 Port: tx_v  out  1  tx_d valid.
REQ-010 Port: tx_rdy  in  1  sink accepts the byte on the posedge where tx_v && tx_rdy.
REQ-011 Port: ovf  out  1  sticky overflow flag.
REQ-012 Port: ovf_clr  in  1  synchronous clear of ovf.
REQ-013 Port: err  out  1  sticky invalid-select flag; cleared only by rst.
REQ-014 Port: frm_cnt  out  8  count of completed frames.

Function
REQ-015 FSM states IDLE, HDR, P0, P1; req_rdy = 1 only in IDLE.
REQ-016 On accept, latch sel and field value; req_sel=3 -> set err, stay in IDLE, emit nothing.
REQ-017 Valid accept -> HDR next cycle, so tx_v rises exactly one cycle after acceptance.
REQ-018 Header byte = {ovf_req, nbm1[1:0], sel[1:0], OPC}; nbm1 = 0 for R8/R4, 1 for RC.
REQ-019 Payload: R8 -> P0 = val[7:0]; R4 -> P0 = {4'h0, val[3:0]}; RC -> P0 = val[7:0], P1 = {4'h0, val[11:8]}.
REQ-020 ovf_req = 1 when req_d has any bit set above the field width (R8: [15:8], R4: [15:4], RC: [15:12]).
REQ-021 Handshake: a byte advances HDR -> P0 -> (P1 for RC) only on tx_v && tx_rdy.
REQ-022 tx_d stays stable while tx_v && !tx_rdy, for any number of stall cycles.
REQ-023 Last payload byte accepted -> IDLE and frm_cnt += 1; frm_cnt wraps 8'hFF -> 8'h00.
REQ-024 In IDLE, tx_v = 0; back-to-back frames therefore carry a one-cycle bubble.
REQ-025 Accepting a request with ovf_req = 1 sets ovf; set wins over a same-cycle ovf_clr.

Reset
REQ-026 While rst is high: state = IDLE, req_rdy = 1 combinationally, tx_v = 0, tx_d = 8'h00, ovf = 0, err = 0, frm_cnt = 0.
REQ-027 Reset mid-frame abandons the frame: tx_v drops asynchronously, no partial frame resumes, and frm_cnt does not increment.

Configuration
REQ-028 Macro OVF_SAT_EN defined: an overflowing value saturates to the field maximum (R8 8'hFF, R4 4'hF, RC 12'hFFF).
REQ-029 Macro OVF_SAT_EN undefined: an overflowing value truncates to its low field bits; header and ovf behaviour are identical in both builds.

Verification
REQ-030 R8, req_d=16'h00A5, tx_rdy=1 -> bytes 0x01, 0xA5; ovf=0; frm_cnt=1.
REQ-031 R4, req_d=16'h00F3 -> bytes 0x89 then 0x03 (truncate build) or 0x0F (OVF_SAT_EN build); ovf=1.
REQ-032 RC, req_d=16'h0ABC, tx_rdy low 3 cycles during HDR -> 0x31 held stable, then 0xBC, 0x0A; ovf unchanged.
REQ-033 RC, req_d=16'hF0F1 -> bytes 0xB1, 0xF1, 0x00 (truncate build) or 0xB1, 0xFF, 0x0F (OVF_SAT_EN build); ovf_clr pulsed in the same cycle as acceptance -> ovf=1.
REQ-034 req_sel=3 -> no tx_v, err=1, req_rdy stays 1; a following R8 16'h0011 request -> bytes 0x01, 0x11.
REQ-035 rst pulsed during P0 of an RC frame -> tx_v=0 immediately, frm_cnt=0, and the next request produces a clean header.

Source files
------------

// File: rtl/ovf_cmd_tx_if.sv
// Request/transmit/status bundle between a command source and ovf_cmd_tx.
// The master modport is the request side; the slave modport is the encoder itself.
interface ovf_cmd_tx_if;
   logic        req_v;
   logic [1:0]  req_sel;
   logic [15:0] req_d;
   logic        req_rdy;
   logic [7:0]  tx_d;
   logic        tx_v;
   logic        tx_rdy;
   logic        ovf;
   logic        ovf_clr;
   logic        err;
   logic [7:0]  frm_cnt;

   modport master (
      output req_v, req_sel, req_d, tx_rdy, ovf_clr,
      input  req_rdy, tx_d, tx_v, ovf, err, frm_cnt
   );

   modport slave (
      input  req_v, req_sel, req_d, tx_rdy, ovf_clr,
      output req_rdy, tx_d, tx_v, ovf, err, frm_cnt
   );
endinterface

// File: rtl/ovf_cmd_tx.sv
// Register-write command encoder: turns one accepted request into a header byte plus 1-2 payload bytes.
// Define OVF_SAT_EN to saturate overflowing values to the field maximum instead of truncating them.
module ovf_cmd_tx #(
   parameter logic [2:0] OPC = 3'h1
) (
   input logic         clk,
   input logic         rst,
   ovf_cmd_tx_if.slave bus
);

   typedef enum logic [1:0] {IDLE, HDR, P0, P1} state_t;

   localparam logic [1:0] SEL_R8  = 2'd0;
   localparam logic [1:0] SEL_R4  = 2'd1;
   localparam logic [1:0] SEL_RC  = 2'd2;
   localparam logic [1:0] SEL_INV = 2'd3;

   state_t      state_q, state_d;
   logic [1:0]  sel_q;
   logic [11:0] val_q;
   logic        ovfReq_q;
   logic        ovf_q;
   logic        err_q;
   logic [7:0]  frmCnt_q;

   logic        accept;
   logic        validAccept;
   logic        txFire;
   logic        lastByte;
   logic        reqOvf;
   logic [11:0] fieldVal;
   logic [1:0]  nbm1;

   assign accept      = bus.req_v && (state_q == IDLE);
   assign validAccept = accept && (bus.req_sel != SEL_INV);
   assign txFire      = (state_q != IDLE) && bus.tx_rdy;
   assign lastByte    = (state_q == P1) || ((state_q == P0) && (sel_q != SEL_RC));
   assign nbm1        = (sel_q == SEL_RC) ? 2'b01 : 2'b00;

   // Overflow detection looks at bits above the selected field; the stored value is already trimmed to the field.
   always_comb begin
      reqOvf   = 1'b0;
      fieldVal = 12'h000;
      case (bus.req_sel)
         SEL_R8: begin
            reqOvf   = |bus.req_d[15:8];
            fieldVal = {4'h0, bus.req_d[7:0]};
`ifdef OVF_SAT_EN
            if (reqOvf) fieldVal = 12'h0FF;
`endif
         end
         SEL_R4: begin
            reqOvf   = |bus.req_d[15:4];
            fieldVal = {8'h00, bus.req_d[3:0]};
`ifdef OVF_SAT_EN
            if (reqOvf) fieldVal = 12'h00F;
`endif
         end
         SEL_RC: begin
            reqOvf   = |bus.req_d[15:12];
            fieldVal = bus.req_d[11:0];
`ifdef OVF_SAT_EN
            if (reqOvf) fieldVal = 12'hFFF;
`endif
         end
         default: begin
            reqOvf   = 1'b0;
            fieldVal = 12'h000;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Each byte only advances on a sink handshake; RC frames take the extra P1 byte.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (validAccept) state_d = HDR;
         HDR:  if (bus.tx_rdy)  state_d = P0;
         P0:   if (bus.tx_rdy)  state_d = (sel_q == SEL_RC) ? P1 : IDLE;
         P1:   if (bus.tx_rdy)  state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_rdy = 1'b0;
      bus.tx_v    = 1'b0;
      bus.tx_d    = 8'h00;
      case (state_q)
         IDLE: bus.req_rdy = 1'b1;
         HDR: begin
            bus.tx_v = 1'b1;
            bus.tx_d = {ovfReq_q, nbm1, sel_q, OPC};
         end
         P0: begin
            bus.tx_v = 1'b1;
            bus.tx_d = (sel_q == SEL_R4) ? {4'h0, val_q[3:0]} : val_q[7:0];
         end
         P1: begin
            bus.tx_v = 1'b1;
            bus.tx_d = {4'h0, val_q[11:8]};
         end
         default: bus.req_rdy = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q    <= SEL_R8;
         val_q    <= 12'h000;
         ovfReq_q <= 1'b0;
      end else if (validAccept) begin
         sel_q    <= bus.req_sel;
         val_q    <= fieldVal;
         ovfReq_q <= reqOvf;
      end
   end

   // A same-cycle set beats the clear so an overflow is never lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (validAccept && reqOvf) begin
         ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
         ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (accept && (bus.req_sel == SEL_INV)) begin
         err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frmCnt_q <= 8'h00;
      end else if (txFire && lastByte) begin
         frmCnt_q <= frmCnt_q + 8'h01;
      end
   end

   assign bus.ovf     = ovf_q;
   assign bus.err     = err_q;
   assign bus.frm_cnt = frmCnt_q;

endmodule

// File: tb/tb_ovf_cmd_tx.sv
// Directed bench for ovf_cmd_tx: a table of frames plus hand sequences for invalid select, wrap and mid-frame reset.
// Expected payloads follow the OVF_SAT_EN setting of the build.
module tb_ovf_cmd_tx;

   typedef struct {
      logic [1:0]  sel;
      logic [15:0] data;
      int          stall;
      bit          preClr;
      bit          clrAtAccept;
      int          nBytes;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  b2;
      bit          expOvf;
   } vec_t;

`ifdef OVF_SAT_EN
   localparam logic [7:0] R4F3_P0  = 8'h0F;
   localparam logic [7:0] RCOV_P0  = 8'hFF;
   localparam logic [7:0] RCOV_P1  = 8'h0F;
   localparam logic [7:0] R8OV_P0  = 8'hFF;
`else
   localparam logic [7:0] R4F3_P0  = 8'h03;
   localparam logic [7:0] RCOV_P0  = 8'hF1;
   localparam logic [7:0] RCOV_P1  = 8'h00;
   localparam logic [7:0] R8OV_P0  = 8'h00;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [7:0] expFrm;
   vec_t vecs[7];

   ovf_cmd_tx_if bus();

   ovf_cmd_tx #(.OPC(3'h1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against the bench's own expectation.
   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Present one request and hold it through the accepting posedge.
   task automatic applyStimulus(input logic [1:0] sel, input logic [15:0] data, input bit clr);
      int waitCnt;
      waitCnt = 0;
      while (!bus.req_rdy && waitCnt < 20) begin
         @(posedge clk);
         #1;
         waitCnt++;
      end
      if (!bus.req_rdy) checkOutput("req_rdy timeout", 16'(bus.req_rdy), 16'h1);
      bus.req_v   = 1'b1;
      bus.req_sel = sel;
      bus.req_d   = data;
      bus.ovf_clr = clr;
      @(posedge clk);
      #1;
      bus.req_v   = 1'b0;
      bus.ovf_clr = 1'b0;
   endtask

   // Drive a whole frame and check every byte, the bubble, ovf and the frame counter.
   task automatic runFrame(input vec_t v);
      logic [7:0] expB[3];
      expB[0] = v.b0;
      expB[1] = v.b1;
      expB[2] = v.b2;
      if (v.preClr) begin
         bus.ovf_clr = 1'b1;
         @(posedge clk);
         #1;
         bus.ovf_clr = 1'b0;
      end
      applyStimulus(v.sel, v.data, v.clrAtAccept);
      for (int k = 0; k < v.nBytes; k++) begin
         if (k == 0) begin
            for (int s = 0; s < v.stall; s++) begin
               bus.tx_rdy = 1'b0;
               @(negedge clk);
               checkOutput("stall tx_v", 16'(bus.tx_v), 16'h1);
               checkOutput("stall tx_d", 16'(bus.tx_d), 16'(expB[k]));
               @(posedge clk);
               #1;
            end
         end
         bus.tx_rdy = 1'b1;
         @(negedge clk);
         checkOutput("tx_v", 16'(bus.tx_v), 16'h1);
         checkOutput("tx_d", 16'(bus.tx_d), 16'(expB[k]));
         @(posedge clk);
         #1;
      end
      expFrm = expFrm + 8'h01;
      @(negedge clk);
      checkOutput("bubble tx_v", 16'(bus.tx_v), 16'h0);
      checkOutput("ovf", 16'(bus.ovf), 16'(v.expOvf));
      checkOutput("frm_cnt", 16'(bus.frm_cnt), 16'(expFrm));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t hv;
      checks      = 0;
      errors      = 0;
      expFrm      = 8'h00;
      rst         = 1'b1;
      bus.req_v   = 1'b0;
      bus.req_sel = 2'd0;
      bus.req_d   = 16'h0000;
      bus.tx_rdy  = 1'b1;
      bus.ovf_clr = 1'b0;

      //           sel    data      stall preClr clrAcc n  b0     b1       b2       ovf
      vecs[0] = '{2'd0, 16'h00A5, 0,    1'b0,  1'b0,  2, 8'h01, 8'hA5,   8'h00,   1'b0};
      vecs[1] = '{2'd1, 16'h00F3, 0,    1'b0,  1'b0,  2, 8'h89, R4F3_P0, 8'h00,   1'b1};
      vecs[2] = '{2'd2, 16'h0ABC, 3,    1'b1,  1'b0,  3, 8'h31, 8'hBC,   8'h0A,   1'b0};
      vecs[3] = '{2'd2, 16'hF0F1, 0,    1'b1,  1'b1,  3, 8'hB1, RCOV_P0, RCOV_P1, 1'b1};
      vecs[4] = '{2'd0, 16'h0011, 1,    1'b0,  1'b0,  2, 8'h01, 8'h11,   8'h00,   1'b1};
      vecs[5] = '{2'd1, 16'h0007, 0,    1'b0,  1'b0,  2, 8'h09, 8'h07,   8'h00,   1'b1};
      vecs[6] = '{2'd0, 16'h0100, 0,    1'b0,  1'b0,  2, 8'h81, R8OV_P0, 8'h00,   1'b1};

      #3;
      checkOutput("reset req_rdy", 16'(bus.req_rdy), 16'h1);
      checkOutput("reset tx_v", 16'(bus.tx_v), 16'h0);
      checkOutput("reset tx_d", 16'(bus.tx_d), 16'h00);
      checkOutput("reset ovf", 16'(bus.ovf), 16'h0);
      checkOutput("reset err", 16'(bus.err), 16'h0);
      checkOutput("reset frm_cnt", 16'(bus.frm_cnt), 16'h00);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) runFrame(vecs[i]);

      applyStimulus(2'd3, 16'h1234, 1'b0);
      @(negedge clk);
      checkOutput("invalid tx_v", 16'(bus.tx_v), 16'h0);
      checkOutput("invalid err", 16'(bus.err), 16'h1);
      checkOutput("invalid req_rdy", 16'(bus.req_rdy), 16'h1);
      checkOutput("invalid frm_cnt", 16'(bus.frm_cnt), 16'(expFrm));
      hv = '{2'd0, 16'h0011, 0, 1'b0, 1'b0, 2, 8'h01, 8'h11, 8'h00, 1'b1};
      runFrame(hv);
      checkOutput("err sticky", 16'(bus.err), 16'h1);

      hv = '{2'd0, 16'h00A5, 0, 1'b0, 1'b0, 2, 8'h01, 8'hA5, 8'h00, 1'b1};
      while (expFrm != 8'hFF) runFrame(hv);
      checkOutput("frm_cnt at max", 16'(bus.frm_cnt), 16'h00FF);
      runFrame(hv);
      checkOutput("frm_cnt wrapped", 16'(bus.frm_cnt), 16'h0000);

      applyStimulus(2'd2, 16'h0ABC, 1'b0);
      bus.tx_rdy = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("P0 before reset tx_d", 16'(bus.tx_d), 16'h00BC);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midreset tx_v", 16'(bus.tx_v), 16'h0);
      checkOutput("midreset tx_d", 16'(bus.tx_d), 16'h00);
      checkOutput("midreset req_rdy", 16'(bus.req_rdy), 16'h1);
      checkOutput("midreset frm_cnt", 16'(bus.frm_cnt), 16'h00);
      checkOutput("midreset ovf", 16'(bus.ovf), 16'h0);
      checkOutput("midreset err", 16'(bus.err), 16'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      expFrm = 8'h00;
      checkOutput("post reset tx_v", 16'(bus.tx_v), 16'h0);
      hv = '{2'd0, 16'h00A5, 0, 1'b0, 1'b0, 2, 8'h01, 8'hA5, 8'h00, 1'b0};
      runFrame(hv);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
